cic_comb_decimator: RTL
=======================

# cic_comb_decimator

Comb-and-decimate back end of the CIC decimation filter. It consumes the running sums produced by the integrator/accumulator registers and, for every DECIM-th valid sample, forms the cascaded first differences that undo the integration. It outputs one scaled, decimated sample with a single-cycle valid strobe. It sits between the integrator chain and the downstream audio-rate processing.

## Interface

- WIDTH, 16 — data width of the input, internal comb registers and output; two's complement.
- DECIM, 8 — decimation ratio; legal range 1..256.
- STAGES, 3 — number of comb stages (differential delay M = 1); legal range 1..4.
- SHIFT, 0 — arithmetic right-shift applied at the output for gain normalisation; legal range 0..WIDTH-1.

- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous and active-high on CLK.
- IN_DATA  input  WIDTH  integrator output; sampled only when IN_VALID = 1.
- IN_VALID  input  1  input sample strobe; any duty cycle, including continuous.
- OUT_DATA  output  WIDTH  decimated, comb-filtered, shifted sample; holds its value between strobes.
- OUT_VALID  output  1  single-cycle strobe marking a new OUT_DATA.

## Operation

- Decimation counter CNT, range 0..DECIM-1:
  - increments on each edge with IN_VALID = 1;
  - wraps to 0 after DECIM-1;
  - holds when IN_VALID = 0.
- Accept event: IN_VALID = 1 and CNT = DECIM-1. Only accepted samples enter the comb.
  - DECIM = 1 accepts every valid sample.
- Each comb stage i (1..STAGES) has a delay register P_i, a result register S_i and a valid bit V_i.
  - On stage i's input strobe: S_i <= x - P_i and P_i <= x.
  - x is IN_DATA for stage 1 and S_(i-1) for later stages.
  - Stage i's input strobe is the accept event for stage 1 and V_(i-1) otherwise.
- All arithmetic is modulo 2^WIDTH with no saturation inside the comb. Wrap-around is required for correct CIC operation.
- Output stage:
  - OUT_DATA <= shift(S_STAGES) when V_STAGES = 1;
  - OUT_VALID <= V_STAGES; otherwise OUT_VALID <= 0.
- Stages advance independently, so back-to-back accepts (DECIM = 1) are fully pipelined with no stalls and no overrun condition.
- Start-up: the delay registers start at zero, so the first STAGES outputs after reset are transient. This is normal CIC behaviour and is not suppressed.

## Timing

- Reset values, asserted at the first edge with RST = 1:
  - CNT, all P_i, S_i and V_i = 0;
  - OUT_DATA = 0, OUT_VALID = 0.
- RST dominates: IN_VALID is ignored on any edge with RST = 1.
- Reset mid-operation discards in-flight samples; OUT_VALID is 0 from the edge after RST.
- Latency: an accept at edge k produces OUT_VALID = 1 during the cycle after edge k+STAGES, a total of STAGES+1 edges.
- OUT_VALID is never high on two consecutive cycles unless DECIM = 1 with consecutive accepts.
- Throughput is one output per DECIM valid inputs.

## Configuration

- CIC_COMB_ROUND_EN defined:
  - output = (S_STAGES + 2^(SHIFT-1)) >>> SHIFT, i.e. round half up;
  - the addition saturates at +(2^(WIDTH-1)-1) before the shift;
  - with SHIFT = 0 no rounding is applied.
- CIC_COMB_ROUND_EN undefined:
  - output = S_STAGES >>> SHIFT, an arithmetic shift that truncates toward negative infinity;
  - no rounding adder and no saturation logic are present.

## Test plan

- Reset: hold RST for 3 cycles with IN_VALID = 1 and random IN_DATA -> OUT_DATA = 0, OUT_VALID = 0, and the first accept occurs on the DECIM-th valid sample after RST falls.
- Impulse response, defaults with SHIFT = 0 and DECIM = 1: IN_DATA = 100 held on every valid -> OUT_DATA sequence 100, -200, 100, 0, 0…; each strobe arrives 4 cycles after its accept.
- Decimation with gaps, DECIM = 8: IN_VALID toggled 1,0,1,0… -> exactly one OUT_VALID per 8 valid samples (every 16 cycles), each a single-cycle pulse; CNT holds through the gaps.
- Wrap-around, STAGES = 1 and DECIM = 1: IN_DATA 0x7FF0 then 0x8010 -> second output is 0x0020.
- Mid-operation reset: RST asserted for 1 cycle one edge after an accept -> no OUT_VALID from that sample, and all delay registers read back as zero on the next impulse (first output equals the input).
- Rounding, SHIFT = 2 and STAGES = 1, S = 6, -6, 0x7FFF:
  - with CIC_COMB_ROUND_EN -> 2, -1, 0x1FFF;
  - without -> 1, -2, 0x1FFF.

Source files
------------

// File: rtl/cic_comb_decimator_if.sv
// Sample stream bundle for the CIC comb/decimate stage: data word plus valid strobe.
// master drives the stream, slave receives it.
interface cic_comb_decimator_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] data;
    logic             valid;

    modport master (output data, output valid);
    modport slave  (input  data, input  valid);
endinterface

// File: rtl/cic_comb_decimator.sv
// CIC comb-and-decimate back end: keeps every DECIM-th integrator sample, runs STAGES
// first-difference combs (M = 1), then scales the result. Define CIC_COMB_ROUND_EN to get round-half-up scaling.
module cic_comb_decimator #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DECIM  = 8,
    parameter int unsigned STAGES = 3,
    parameter int unsigned SHIFT  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    cic_comb_decimator_if.slave  src,
    cic_comb_decimator_if.master dst
);
    localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    logic [CNT_W-1:0] cnt;
    logic             accept_c;

    logic [WIDTH-1:0]  dly   [STAGES];
    logic [WIDTH-1:0]  diff  [STAGES];
    logic [STAGES-1:0] vld;
    logic [WIDTH-1:0]  stage_in_c  [STAGES];
    logic [STAGES-1:0] stage_stb_c;
    logic [WIDTH-1:0]  scaled_c;

    assign accept_c = src.valid && (cnt == CNT_LAST);

    // Decimation phase counter, advances only on valid input samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (src.valid) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    // Stage i is fed by stage i-1; stage 0 by accepted input samples.
    always_comb begin
        stage_in_c[0]  = src.data;
        stage_stb_c[0] = accept_c;
        for (int i = 1; i < int'(STAGES); i++) begin
            stage_in_c[i]  = diff[i-1];
            stage_stb_c[i] = vld[i-1];
        end
    end

    // Each comb stage advances independently on its own strobe, so accepts pipeline freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                dly[i]  <= '0;
                diff[i] <= '0;
            end
        end else begin
            vld <= stage_stb_c;
            for (int i = 0; i < int'(STAGES); i++) begin
                if (stage_stb_c[i]) begin
                    diff[i] <= stage_in_c[i] - dly[i];
                    dly[i]  <= stage_in_c[i];
                end
            end
        end
    end

`ifdef CIC_COMB_ROUND_EN
    localparam int unsigned    HALF_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [WIDTH:0] HALF     = (WIDTH+1)'((SHIFT > 0) ? (1 << HALF_POS) : 0);
    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    logic [WIDTH:0]   rnd_sum_c;
    logic [WIDTH-1:0] rnd_sat_c;

    // Round half up; the bias can only overflow upward, which clamps to the positive maximum.
    always_comb begin
        rnd_sum_c = {diff[STAGES-1][WIDTH-1], diff[STAGES-1]} + HALF;
        rnd_sat_c = rnd_sum_c[WIDTH-1:0];
        if (rnd_sum_c[WIDTH:WIDTH-1] == 2'b01) begin
            rnd_sat_c = POS_MAX;
        end
        scaled_c = WIDTH'($signed(rnd_sat_c) >>> SHIFT);
    end
`else
    assign scaled_c = WIDTH'($signed(diff[STAGES-1]) >>> SHIFT);
`endif

    // Output register: data holds between strobes, valid is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            dst.data  <= '0;
            dst.valid <= 1'b0;
        end else begin
            dst.valid <= vld[STAGES-1];
            if (vld[STAGES-1]) begin
                dst.data <= scaled_c;
            end
        end
    end
endmodule
